// File: rtl/icu_line_fill_resp.sv
// BIU-side line-fill responder: acknowledges an icache miss, reads the line one
// doubleword at a time from the memory port and streams the beats back to the ICU.
module icu_line_fill_resp #(
  parameter int LINE_BEATS = 4,
  parameter int BEAT_IDX_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        icu_biu_req,
  input  logic [28:0] icu_biu_addr,
  output logic        biu_icu_ack,
  output logic [63:0] biu_icu_data,
  output logic        biu_icu_data_valid,
  output logic        biu_icu_data_last,
  output logic        biu_mem_req,
  output logic [28:0] biu_mem_addr,
  input  logic        mem_biu_gnt,
  input  logic        mem_biu_rvalid,
  input  logic [63:0] mem_biu_rdata,
  output logic        biu_busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACK  = 2'd1;
  localparam logic [1:0] S_REQ  = 2'd2;
  localparam logic [1:0] S_WAIT = 2'd3;

  logic [1:0]             r_state;
  logic [28-BEAT_IDX_W:0] r_line;
  logic [BEAT_IDX_W-1:0]  r_beat_cnt;
  logic [63:0]            r_data;
  logic                   r_valid;
  logic                   r_last;
  logic                   w_cnt_last;
  logic                   w_unused_ofs;

  assign w_cnt_last   = (r_beat_cnt == BEAT_IDX_W'(LINE_BEATS - 1));
  // Word-offset bits of the miss address never reach the line base.
  assign w_unused_ofs = ^icu_biu_addr[BEAT_IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_line     <= '0;
      r_beat_cnt <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // The cycle showing the last beat still counts as busy, so no accept there.
          if (icu_biu_req && !r_last) begin
            r_line     <= icu_biu_addr[28:BEAT_IDX_W];
            r_beat_cnt <= '0;
            r_state    <= S_ACK;
          end
        end
        S_ACK: r_state <= S_REQ;
        S_REQ: begin
          if (mem_biu_gnt) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_biu_rvalid) begin
            r_data  <= mem_biu_rdata;
            r_valid <= 1'b1;
            r_last  <= w_cnt_last;
            if (w_cnt_last) begin
              r_state <= S_IDLE;
            end else begin
              r_beat_cnt <= r_beat_cnt + 1'b1;
              r_state    <= S_REQ;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign biu_icu_ack        = (r_state == S_ACK);
  assign biu_icu_data       = r_data;
  assign biu_icu_data_valid = r_valid;
  assign biu_icu_data_last  = r_last;
  assign biu_mem_req        = (r_state == S_REQ);
  // Beat index fills the cleared offset bits, so the address never carries out of the line.
  assign biu_mem_addr       = {r_line, r_beat_cnt};
  assign biu_busy           = (r_state != S_IDLE) || r_last;

endmodule

// File: tb/tb_icu_line_fill_resp.sv
// Directed bench for icu_line_fill_resp with a one-outstanding-read memory responder.
module tb_icu_line_fill_resp;

  logic        clk = 1'b0;
  logic        reset;
  logic        icu_biu_req;
  logic [28:0] icu_biu_addr;
  logic        biu_icu_ack;
  logic [63:0] biu_icu_data;
  logic        biu_icu_data_valid;
  logic        biu_icu_data_last;
  logic        biu_mem_req;
  logic [28:0] biu_mem_addr;
  logic        mem_biu_gnt;
  logic        mem_biu_rvalid;
  logic [63:0] mem_biu_rdata;
  logic        biu_busy;

  icu_line_fill_resp #(.LINE_BEATS(4), .BEAT_IDX_W(2)) dut (
    .clk               (clk),
    .reset             (reset),
    .icu_biu_req       (icu_biu_req),
    .icu_biu_addr      (icu_biu_addr),
    .biu_icu_ack       (biu_icu_ack),
    .biu_icu_data      (biu_icu_data),
    .biu_icu_data_valid(biu_icu_data_valid),
    .biu_icu_data_last (biu_icu_data_last),
    .biu_mem_req       (biu_mem_req),
    .biu_mem_addr      (biu_mem_addr),
    .mem_biu_gnt       (mem_biu_gnt),
    .mem_biu_rvalid    (mem_biu_rvalid),
    .mem_biu_rdata     (mem_biu_rdata),
    .biu_busy          (biu_busy)
  );

  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_pass = 0;
  int          cyc    = 0;
  int          n_last = 0;
  int          stall_left = 0;
  bit          pend = 1'b0;
  logic [28:0] pend_addr;
  logic [63:0] beat_q[$];
  bit          last_q[$];
  int          ack_q[$];
  logic [28:0] g_addr[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Memory contents: line 0x2020 holds b/c/d/e patterns, other words a tagged address.
  function automatic logic [63:0] mem_data(input logic [28:0] a);
    logic [3:0] nib;
    if (a[28:2] == 27'h808) begin
      nib = 4'hb + {2'b00, a[1:0]};
      return {16{nib}};
    end
    return {3'b000, a, 32'hA5A5_A5A5};
  endfunction

  function automatic logic [63:0] exp_data(input logic [28:0] base, input int i);
    if (base == 29'h2020) begin
      case (i)
        0: return 64'hbbbb_bbbb_bbbb_bbbb;
        1: return 64'hcccc_cccc_cccc_cccc;
        2: return 64'hdddd_dddd_dddd_dddd;
        default: return 64'heeee_eeee_eeee_eeee;
      endcase
    end
    return {3'b000, base + 29'(i), 32'hA5A5_A5A5};
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor plus memory responder: grant immediately, rvalid one cycle after grant.
  initial begin
    mem_biu_gnt    = 1'b0;
    mem_biu_rvalid = 1'b0;
    mem_biu_rdata  = '0;
    forever begin
      @(negedge clk);
      if (biu_icu_data_valid) begin
        beat_q.push_back(biu_icu_data);
        last_q.push_back(biu_icu_data_last);
        if (biu_icu_data_last) n_last++;
        $display("beat %0d data=0x%016h last=%0b", beat_q.size() - 1, biu_icu_data, biu_icu_data_last);
      end
      if (biu_icu_ack) ack_q.push_back(cyc);
      mem_biu_gnt    = 1'b0;
      mem_biu_rvalid = 1'b0;
      if (pend) begin
        mem_biu_rvalid = 1'b1;
        mem_biu_rdata  = mem_data(pend_addr);
        pend = 1'b0;
      end else if (biu_mem_req) begin
        if (stall_left > 0 && g_addr.size() == 2) begin
          chk("stall_addr", 64'(biu_mem_addr), 64'h2022);
          stall_left--;
        end else begin
          mem_biu_gnt = 1'b1;
          pend        = 1'b1;
          pend_addr   = biu_mem_addr;
          g_addr.push_back(biu_mem_addr);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    beat_q.delete();
    last_q.delete();
    ack_q.delete();
    g_addr.delete();
  endtask

  task automatic start_fill(input logic [28:0] a, output int t_req);
    clear_logs();
    icu_biu_req  = 1'b1;
    icu_biu_addr = a;
    t_req        = cyc;
    tick();
    icu_biu_req  = 1'b0;
    chk("ack_t1", 64'(biu_icu_ack), 64'd1);
    chk("busy_ack", 64'(biu_busy), 64'd1);
  endtask

  task automatic wait_beats(input int n);
    bit done = 1'b0;
    for (int i = 0; i < 80 && !done; i++) begin
      tick();
      if (beat_q.size() >= n) done = 1'b1;
    end
    if (!done) chk("timeout", 64'd0, 64'd1);
  endtask

  task automatic check_fill(input string name, input logic [28:0] base, input int t_req);
    chk({name, "_n_beats"}, 64'(beat_q.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < beat_q.size()) begin
        chk({name, "_data"}, beat_q[i], exp_data(base, i));
        chk({name, "_last"}, 64'(last_q[i]), 64'(i == 3));
      end
    end
    chk({name, "_n_reads"}, 64'(g_addr.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < g_addr.size()) chk({name, "_addr"}, 64'(g_addr[i]), 64'(base + 29'(i)));
    end
    chk({name, "_n_ack"}, 64'(ack_q.size()), 64'd1);
    if (ack_q.size() > 0) chk({name, "_ack_cyc"}, 64'(ack_q[0]), 64'(t_req + 1));
    chk({name, "_busy_last"}, 64'(biu_busy), 64'd1);
    $display("fill %s base=0x%08h beats=%0d reads=%0d", name, base, beat_q.size(), g_addr.size());
  endtask

  task automatic check_zero(input string name);
    chk({name, "_ack"},   64'(biu_icu_ack), 64'd0);
    chk({name, "_data"},  biu_icu_data, 64'd0);
    chk({name, "_valid"}, 64'(biu_icu_data_valid), 64'd0);
    chk({name, "_last"},  64'(biu_icu_data_last), 64'd0);
    chk({name, "_mreq"},  64'(biu_mem_req), 64'd0);
    chk({name, "_maddr"}, 64'(biu_mem_addr), 64'd0);
    chk({name, "_busy"},  64'(biu_busy), 64'd0);
  endtask

  initial begin
    int t;
    reset        = 1'b1;
    icu_biu_req  = 1'b0;
    icu_biu_addr = '0;
    repeat (3) tick();
    check_zero("rst");
    reset = 1'b0;
    tick();

    // Basic fill
    start_fill(29'h2021, t);
    wait_beats(4);
    check_fill("basic", 29'h2020, t);
    tick();
    chk("basic_busy_idle", 64'(biu_busy), 64'd0);
    tick();

    // Grant stall on beat 2
    stall_left = 3;
    start_fill(29'h2021, t);
    wait_beats(4);
    check_fill("stall", 29'h2020, t);
    chk("stall_consumed", 64'(stall_left), 64'd0);
    tick();
    tick();

    // Request while busy is dropped
    start_fill(29'h2021, t);
    wait_beats(1);
    icu_biu_req  = 1'b1;
    icu_biu_addr = 29'h3000;
    tick();
    icu_biu_req  = 1'b0;
    wait_beats(4);
    check_fill("busyreq", 29'h2020, t);

    // Back-to-back: request in the IDLE cycle right after the last beat
    tick();
    chk("b2b_busy_idle", 64'(biu_busy), 64'd0);
    start_fill(29'h4007, t);
    wait_beats(4);
    check_fill("b2b", 29'h4004, t);
    tick();
    tick();

    // Reset mid-fill after the second beat, with a read already granted
    start_fill(29'h2021, t);
    wait_beats(2);
    reset = 1'b1;
    tick();
    check_zero("midrst");
    reset = 1'b0;
    beat_q.delete();
    last_q.delete();
    repeat (3) tick();
    chk("midrst_no_beat", 64'(beat_q.size()), 64'd0);
    start_fill(29'h2021, t);
    wait_beats(4);
    check_fill("postrst", 29'h2020, t);
    tick();
    tick();

    // Top of address space
    start_fill(29'h1FFF_FFFF, t);
    wait_beats(4);
    check_fill("top", 29'h1FFF_FFFC, t);
    tick();
    chk("top_busy_idle", 64'(biu_busy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
